bench_run_controller: RTL
=========================

Name: bench_run_controller

Overview:
Synthesizable run controller that sequences a benchmark on the cpu core and measures it. It holds the core in reset for a parametrised number of cycles, then releases it. It detects program halt as a branch-to-self, where the PC stays unchanged for several cycles, and enforces a cycle budget. It reports cycle and retired-instruction counts plus a done/timeout status. It sits beside the cpu instance in the top level and in benches, and drives the core's reset.

Parameters:
MAX_CYCLES, 10000, cycle budget for one run; reaching it ends the run with timeout
COUNT_WIDTH, 32, width of cycle_count and instr_count; elaboration assertion requires MAX_CYCLES < 2**COUNT_WIDTH
ADDR_WIDTH, 64, width of observed PC
RESET_CYCLES, 1, cycles cpu_reset is held after start (>=1)
HALT_STABLE, 4, consecutive equal-PC comparisons that declare halt (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; returns block to IDLE
start  input  1  single-cycle request to begin a run
pc  input  ADDR_WIDTH  core program counter, sampled each cycle
retire  input  1  core retired one instruction this cycle
cpu_reset  output  1  reset driven to the core
running  output  1  core executing under measurement
done  output  1  run finished; sticky until next accepted start
timeout  output  1  run ended by budget rather than halt; valid when done=1
cycle_count  output  COUNT_WIDTH  cycles spent in RUN
instr_count  output  COUNT_WIDTH  retire pulses seen in RUN

Behaviour:
- Reset (async) values: state=IDLE, cpu_reset=1, running=0, done=0, timeout=0, counts=0, halt detector cleared. This also applies mid-run: the effect is immediate, with no drain.
- Outputs are Moore, decoded from registered state and registers:
  - IDLE: cpu_reset=1.
  - HOLD: cpu_reset=1.
  - RUN: cpu_reset=0, running=1.
  - DONE: cpu_reset=0, running=0, done=1. The core is left un-reset so its state stays inspectable.
- IDLE: start=1 moves to HOLD. On that edge cycle_count, instr_count, timeout and the hold counter are cleared.
- HOLD: lasts exactly RESET_CYCLES cycles, then moves to RUN.
- RUN, every cycle:
  - cycle_count increments by 1.
  - retire=1 increments instr_count, saturating at all-ones.
  - The halt detector compares pc with the previous cycle's pc. Equal increments the stable count; unequal clears it.
  - The first RUN cycle only loads the previous-pc register; no comparison is made.
- RUN exits:
  - Halt: the stable count reaches HALT_STABLE. Go to DONE, timeout=0.
  - Budget: cycle_count becomes MAX_CYCLES on this edge. Go to DONE, timeout=1.
  - Both on the same cycle: halt wins, timeout=0.
  - The terminating cycle is counted.
- DONE: counters are frozen. start=1 re-enters HOLD and clears counts, done and timeout.
- start is ignored while in HOLD or RUN.
- retire is ignored outside RUN.

Optional Feature:
Macro: CPU_BENCH_TRACE_EN
- Defined: simulation-only.
  - $display of cycle_count and pc on every retire in RUN.
  - One summary line on entry to DONE: cycles, instructions, halt/timeout.
- Undefined: no display code is compiled; RTL behaviour is identical.

Decomposition:
- Package bench_pkg:
  - typedef enum bench_state_e {IDLE, HOLD, RUN, DONE}.
  - Default constants for MAX_CYCLES and COUNT_WIDTH.
- Sub-module pc_halt_detector, parameters ADDR_WIDTH and HALT_STABLE. It contains:
  - the previous-pc register;
  - a first-cycle valid flag;
  - a stable counter.
  - Inputs: clk, reset, clear, enable, pc. Output: halt.

Test Plan:
1. Reset, then start pulse with RESET_CYCLES=1 -> cpu_reset=1 through IDLE and one HOLD cycle; running=1 on the following cycle; done=0.
2. RUN with pc sequence 0,4,8,12,12,12,12,12 and HALT_STABLE=4 -> DONE after the 8th RUN cycle; cycle_count=8, timeout=0, done=1.
3. MAX_CYCLES=20 with pc incrementing by 4 every cycle -> done=1, timeout=1, cycle_count=20; values hold for 10 further cycles.
4. MAX_CYCLES=8 with the scenario-2 pc sequence -> halt and budget coincide on cycle 8; timeout=0.
5. retire high on 5 of 8 RUN cycles, plus a start pulse mid-RUN -> instr_count=5 and the start has no effect. A start in DONE then clears both counts to 0 and re-enters HOLD.
6. reset asserted between clock edges mid-RUN -> immediately cpu_reset=1, running=0, counts=0, state IDLE. A later start runs normally.

Source files
------------

// File: rtl/bench_run_controller_pkg.sv
// Shared state encoding and default sizing for the benchmark run controller.
package bench_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RUN,
    DONE
  } bench_state_e;

  localparam int unsigned DEFAULT_MAX_CYCLES  = 10000;
  localparam int unsigned DEFAULT_COUNT_WIDTH = 32;

endpackage

// File: rtl/bench_run_controller_halt.sv
// Branch-to-self detector: flags halt when the PC has matched its predecessor
// HALT_STABLE times in a row while enabled.
module pc_halt_detector #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned HALT_STABLE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  halt
);

  localparam int unsigned SW = $clog2(HALT_STABLE + 1);
  localparam logic [SW-1:0] LAST_BEFORE_HALT = SW'(HALT_STABLE - 1);
  localparam logic [SW-1:0] FULL             = SW'(HALT_STABLE);

  logic [ADDR_WIDTH-1:0] prev_pc;
  logic                  valid;
  logic [SW-1:0]         stable;
  logic                  same;

  assign same = valid && (pc == prev_pc);

  // Combinational so the controller can leave RUN on the comparison that completes the streak.
  assign halt = enable && same && (stable == LAST_BEFORE_HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_pc <= '0;
      valid   <= 1'b0;
      stable  <= '0;
    end else if (clear) begin
      prev_pc <= '0;
      valid   <= 1'b0;
      stable  <= '0;
    end else if (enable) begin
      prev_pc <= pc;
      valid   <= 1'b1;
      if (!same) begin
        stable <= '0;
      end else if (stable != FULL) begin
        stable <= stable + SW'(1);
      end
    end
  end

endmodule

// File: rtl/bench_run_controller.sv
// Benchmark run controller: holds the core in reset, runs it until halt or
// cycle budget, and reports counts. Optional trace output: CPU_BENCH_TRACE_EN.
module bench_run_controller
  import bench_pkg::*;
#(
  parameter int unsigned MAX_CYCLES   = DEFAULT_MAX_CYCLES,
  parameter int unsigned COUNT_WIDTH  = DEFAULT_COUNT_WIDTH,
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned HALT_STABLE  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  pc,
  input  logic                   retire,
  output logic                   cpu_reset,
  output logic                   running,
  output logic                   done,
  output logic                   timeout,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  if (COUNT_WIDTH < 64 && ((64'(MAX_CYCLES) >> COUNT_WIDTH) != 64'd0)) begin : g_bad_count_width
    $error("bench_run_controller: MAX_CYCLES must be below 2**COUNT_WIDTH");
  end
  if (MAX_CYCLES < 1 || RESET_CYCLES < 1 || HALT_STABLE < 1) begin : g_bad_params
    $error("bench_run_controller: MAX_CYCLES, RESET_CYCLES and HALT_STABLE must be >= 1");
  end

  localparam int unsigned HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0]          LAST_HOLD  = HW'(RESET_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_CYCLE = COUNT_WIDTH'(MAX_CYCLES - 1);

  bench_state_e  state;
  logic [HW-1:0] hold_cnt;
  logic          accept;
  logic          in_run;
  logic          halt;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign in_run = (state == RUN);

  pc_halt_detector #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .HALT_STABLE(HALT_STABLE)
  ) u_halt (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .enable(in_run),
    .pc    (pc),
    .halt  (halt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      cpu_reset   <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            cpu_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
          end
        end
        HOLD: begin
          if (hold_cnt == LAST_HOLD) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
            running   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        RUN: begin
          cycle_count <= cycle_count + COUNT_WIDTH'(1);
          if (retire && (instr_count != '1)) begin
            instr_count <= instr_count + COUNT_WIDTH'(1);
          end
          // Halt takes priority when it lands on the final budgeted cycle.
          if (halt) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b0;
          end else if (cycle_count == LAST_CYCLE) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cpu_reset <= 1'b1;
          running   <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

`ifdef CPU_BENCH_TRACE_EN
  logic [COUNT_WIDTH-1:0] trace_instr;

  always_comb begin
    trace_instr = instr_count;
    if (retire && (instr_count != '1)) begin
      trace_instr = instr_count + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && in_run) begin
      if (retire) begin
        $display("[bench] cycle %0d retire pc=%h", cycle_count, pc);
      end
      if (halt || (cycle_count == LAST_CYCLE)) begin
        $display("[bench] run end: cycles=%0d instrs=%0d %s", cycle_count + COUNT_WIDTH'(1),
                 trace_instr, halt ? "halt" : "timeout");
      end
    end
  end
`else
  // Trace disabled: no simulation display logic is built.
`endif

endmodule
